// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Opcodes, ALU codes and datapath mux selects used by the FSM and ALU decoder.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_IALU   = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_SRC_I = 3'd0;
    localparam logic [2:0] IMM_SRC_S = 3'd1;
    localparam logic [2:0] IMM_SRC_B = 3'd2;
    localparam logic [2:0] IMM_SRC_J = 3'd3;

    localparam logic [1:0] RESULT_SRC_ALUOUT  = 2'd0;
    localparam logic [1:0] RESULT_SRC_MEMDATA = 2'd1;
    localparam logic [1:0] RESULT_SRC_ALU     = 2'd2;

    localparam logic [1:0] ALU_SRC_A_PC    = 2'd0;
    localparam logic [1:0] ALU_SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] ALU_SRC_A_RS1   = 2'd2;

    localparam logic [1:0] ALU_SRC_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: FSM-requested op or funct3/funct7 decode.
// illegal_o flags funct3 values with no supported ALU operation.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  alu_op_t               alu_op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  op5_i,
    input  logic                  funct7_5_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic                  illegal_o
);

    logic [2:0] funct_code;
    logic [2:0] code;

    always_comb begin
        funct_code = ALU_ADD;
        illegal_o  = 1'b0;
        case (funct3_i)
            F3_ADD:  funct_code = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
            F3_SLT:  funct_code = ALU_SLT;
            F3_OR:   funct_code = ALU_OR;
            F3_AND:  funct_code = ALU_AND;
            default: illegal_o  = 1'b1;
        endcase

        case (alu_op_i)
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_FUNCT: code = funct_code;
            default:     code = ALU_ADD;
        endcase
        alu_control_o = ALU_CTRL_W'(code);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with memory-ready timeout and illegal-instruction trap.
// Outputs are decoded from state; pc_write additionally carries the branch-taken term.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int          ALU_CTRL_W   = 3,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter bit          ENABLE_BNE   = 1'b1,
    parameter bit          ENABLE_JAL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr,
    output logic                  bus_error
);

    localparam int unsigned CW  = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam int unsigned LIM = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(LIM);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            illegal_q, illegal_d;
    logic            bus_q, bus_d;
    alu_op_t         alu_op;
    logic            funct_illegal;
    logic            decode_ok;
    logic            mem_state;
    logic            timeout;
    logic            taken;

    multicycle_control_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (opcode[5]),
        .funct7_5_i    (funct7[5]),
        .alu_control_o (alu_control),
        .illegal_o     (funct_illegal)
    );

    // All legality is settled in S_DECODE so execute states never see a bad funct.
    always_comb begin
        case (opcode)
            OPCODE_LOAD,
            OPCODE_STORE:  decode_ok = 1'b1;
            OPCODE_R:      decode_ok = !funct_illegal && (funct7 == 7'h00 || funct7 == 7'h20);
            OPCODE_IALU:   decode_ok = !funct_illegal;
            OPCODE_BRANCH: decode_ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE && ENABLE_BNE);
            OPCODE_JAL:    decode_ok = ENABLE_JAL;
            default:       decode_ok = 1'b0;
        endcase
    end

    assign mem_state = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    assign timeout   = (MEM_WAIT_MAX != 0) && mem_state && !mem_ready && (wait_q == WAIT_LIMIT);
    assign taken     = (funct3 == F3_BEQ && alu_zero) || (funct3 == F3_BNE && !alu_zero && ENABLE_BNE);

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_d      = bus_q;
        alu_op     = ALUOP_ADD;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = ALU_SRC_A_PC;
        alu_src_b  = ALU_SRC_B_RS2;
        result_src = RESULT_SRC_ALUOUT;
        imm_src    = IMM_SRC_I;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = ALU_SRC_B_FOUR;
                    result_src = RESULT_SRC_ALU;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = ALU_SRC_A_OLDPC;
                alu_src_b = ALU_SRC_B_IMM;
                imm_src   = (opcode == OPCODE_JAL) ? IMM_SRC_J : IMM_SRC_B;
                if (!decode_ok) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    case (opcode)
                        OPCODE_LOAD,
                        OPCODE_STORE:  state_d = S_MEMADR;
                        OPCODE_R:      state_d = S_EXECR;
                        OPCODE_IALU:   state_d = S_EXECI;
                        OPCODE_BRANCH: state_d = S_BRANCH;
                        OPCODE_JAL:    state_d = S_JAL;
                        default:       state_d = S_TRAP;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = ALU_SRC_A_RS1;
                alu_src_b = ALU_SRC_B_IMM;
                imm_src   = (opcode == OPCODE_STORE) ? IMM_SRC_S : IMM_SRC_I;
                state_d   = (opcode == OPCODE_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RESULT_SRC_MEMDATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = ALU_SRC_A_RS1;
                alu_src_b = ALU_SRC_B_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = ALU_SRC_A_RS1;
                alu_src_b = ALU_SRC_B_IMM;
                imm_src   = IMM_SRC_I;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = ALU_SRC_A_RS1;
                alu_src_b = ALU_SRC_B_RS2;
                alu_op    = ALUOP_SUB;
                pc_write  = taken;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = ALU_SRC_A_OLDPC;
                alu_src_b = ALU_SRC_B_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_TRAP;
            bus_d   = 1'b1;
        end

        // Counter only runs while parked in a memory state; any transition clears it.
        if (state_d == state_q && mem_state)
            wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
        else
            wait_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_q     <= bus_d;
        end
    end

    assign illegal_instr = illegal_q;
    assign bus_error     = bus_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences built
// from RV32I multi-cycle semantics, applied from a table, random programs and corner cases.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src, alu_control;
    logic       illegal_instr, bus_error;

    logic       b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write;
    logic [1:0] b_alu_src_a, b_alu_src_b, b_result_src;
    logic [2:0] b_imm_src, b_alu_control;
    logic       b_illegal_instr, b_bus_error;

    multicycle_control #(.ALU_CTRL_W(3), .MEM_WAIT_MAX(15), .ENABLE_BNE(1'b1), .ENABLE_JAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
        .illegal_instr(illegal_instr), .bus_error(bus_error)
    );

    multicycle_control #(.ALU_CTRL_W(3), .MEM_WAIT_MAX(15), .ENABLE_BNE(1'b0), .ENABLE_JAL(1'b0)) dut_nobj (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src), .ir_write(b_ir_write),
        .pc_write(b_pc_write), .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .result_src(b_result_src), .imm_src(b_imm_src), .alu_control(b_alu_control),
        .illegal_instr(b_illegal_instr), .bus_error(b_bus_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] a, b, rs;
        logic [2:0] imm, alu;
        logic       ill, bus;
    } outv_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero;
        logic [2:0] alu;
        logic       taken;
        logic       legal;
    } instr_t;

    int     errors = 0;
    int     checks = 0;
    outv_t  exp_q[$];
    instr_t tbl[$];

    function automatic outv_t got1();
        return outv_t'({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                        alu_src_a, alu_src_b, result_src, imm_src, alu_control,
                        illegal_instr, bus_error});
    endfunction

    task automatic check(input string name, input outv_t e);
        outv_t g;
        g = got1();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, g, e);
        end
    endtask

    task automatic check_bit(input string name, input logic g, input logic e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, g, e);
        end
    endtask

    task automatic cycle(input string name, input outv_t e);
        @(negedge clk);
        check(name, e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        mem_ready = 1'b0;
        cycle("reset", '0);
        rst = 1'b0;
        cycle("idle", '0);
    endtask

    function automatic instr_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic z, input logic [2:0] alu,
                                  input logic tk, input logic lg);
        instr_t r;
        r.name = n; r.op = op; r.f3 = f3; r.f7 = f7; r.zero = z;
        r.alu = alu; r.taken = tk; r.legal = lg;
        return r;
    endfunction

    // Reference ALU function: sub only for R-type with funct7 0x20.
    function automatic logic [2:0] ref_alu(input logic is_r, input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return (is_r && f7 == 7'h20) ? ALU_SUB : ALU_ADD;
        endcase
    endfunction

    // Expected control outputs per cycle with memory always ready.
    function automatic void build(input instr_t r);
        outv_t v;
        exp_q.delete();
        v = '0; v.mem_req = 1; v.ir_write = 1; v.pc_write = 1; v.b = 2'd2; v.rs = 2'd2; v.alu = ALU_ADD;
        exp_q.push_back(v);
        v = '0; v.a = 2'd1; v.b = 2'd1; v.imm = (r.op == 7'b1101111) ? IMM_SRC_J : IMM_SRC_B;
        exp_q.push_back(v);
        if (!r.legal) begin
            v = '0; v.ill = 1;
            repeat (3) exp_q.push_back(v);
        end else begin
            case (r.op)
                7'b0000011: begin
                    v = '0; v.a = 2'd2; v.b = 2'd1; v.imm = IMM_SRC_I; exp_q.push_back(v);
                    v = '0; v.mem_req = 1; v.adr_src = 1; exp_q.push_back(v);
                    v = '0; v.rs = 2'd1; v.reg_write = 1; exp_q.push_back(v);
                end
                7'b0100011: begin
                    v = '0; v.a = 2'd2; v.b = 2'd1; v.imm = IMM_SRC_S; exp_q.push_back(v);
                    v = '0; v.mem_req = 1; v.mem_write = 1; v.adr_src = 1; exp_q.push_back(v);
                end
                7'b0110011: begin
                    v = '0; v.a = 2'd2; v.b = 2'd0; v.alu = r.alu; exp_q.push_back(v);
                    v = '0; v.reg_write = 1; exp_q.push_back(v);
                end
                7'b0010011: begin
                    v = '0; v.a = 2'd2; v.b = 2'd1; v.imm = IMM_SRC_I; v.alu = r.alu; exp_q.push_back(v);
                    v = '0; v.reg_write = 1; exp_q.push_back(v);
                end
                7'b1100011: begin
                    v = '0; v.a = 2'd2; v.b = 2'd0; v.alu = ALU_SUB; v.pc_write = r.taken; exp_q.push_back(v);
                end
                default: begin
                    v = '0; v.a = 2'd1; v.b = 2'd2; v.alu = ALU_ADD; v.pc_write = 1; exp_q.push_back(v);
                    v = '0; v.reg_write = 1; exp_q.push_back(v);
                end
            endcase
        end
    endfunction

    // fw/mw: low-ready cycles before the fetch / data access completes (negative = random 0..4).
    task automatic run_instr(input instr_t r, input int fw, input int mw);
        build(r);
        opcode = r.op; funct3 = r.f3; funct7 = r.f7; alu_zero = r.zero;
        for (int i = 0; i < exp_q.size(); i++) begin
            outv_t e;
            outv_t w;
            int    n;
            e = exp_q[i];
            if (e.mem_req) begin
                n = (i == 0) ? fw : mw;
                if (n < 0) n = int'($urandom_range(0, 4));
                w = '0; w.mem_req = 1; w.mem_write = e.mem_write; w.adr_src = e.adr_src;
                repeat (n) begin
                    mem_ready = 1'b0;
                    cycle({r.name, "_wait"}, w);
                end
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            cycle(r.name, e);
        end
    endtask

    function automatic logic is_legal_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        outv_t  v;
        instr_t r;
        logic [2:0] alu_f3s [4];
        alu_f3s[0] = 3'b000; alu_f3s[1] = 3'b010; alu_f3s[2] = 3'b110; alu_f3s[3] = 3'b111;

        tbl.push_back(mk("lw",      7'b0000011, 3'b010, 7'h00, 0, ALU_ADD, 0, 1));
        tbl.push_back(mk("sw",      7'b0100011, 3'b010, 7'h00, 0, ALU_ADD, 0, 1));
        tbl.push_back(mk("add",     7'b0110011, 3'b000, 7'h00, 0, ALU_ADD, 0, 1));
        tbl.push_back(mk("sub",     7'b0110011, 3'b000, 7'h20, 0, ALU_SUB, 0, 1));
        tbl.push_back(mk("or",      7'b0110011, 3'b110, 7'h00, 0, ALU_OR,  0, 1));
        tbl.push_back(mk("and",     7'b0110011, 3'b111, 7'h00, 0, ALU_AND, 0, 1));
        tbl.push_back(mk("slt",     7'b0110011, 3'b010, 7'h00, 0, ALU_SLT, 0, 1));
        tbl.push_back(mk("addi_f7", 7'b0010011, 3'b000, 7'h20, 0, ALU_ADD, 0, 1));
        tbl.push_back(mk("ori",     7'b0010011, 3'b110, 7'h15, 0, ALU_OR,  0, 1));
        tbl.push_back(mk("slti",    7'b0010011, 3'b010, 7'h7f, 0, ALU_SLT, 0, 1));
        tbl.push_back(mk("beq_z1",  7'b1100011, 3'b000, 7'h00, 1, ALU_SUB, 1, 1));
        tbl.push_back(mk("beq_z0",  7'b1100011, 3'b000, 7'h00, 0, ALU_SUB, 0, 1));
        tbl.push_back(mk("bne_z1",  7'b1100011, 3'b001, 7'h00, 1, ALU_SUB, 0, 1));
        tbl.push_back(mk("bne_z0",  7'b1100011, 3'b001, 7'h00, 0, ALU_SUB, 1, 1));
        tbl.push_back(mk("jal",     7'b1101111, 3'b101, 7'h33, 0, ALU_ADD, 0, 1));
        tbl.push_back(mk("sll_ill", 7'b0110011, 3'b001, 7'h00, 0, ALU_ADD, 0, 0));
        tbl.push_back(mk("f7_ill",  7'b0110011, 3'b000, 7'h01, 0, ALU_ADD, 0, 0));
        tbl.push_back(mk("op7f",    7'b1111111, 3'b000, 7'h00, 0, ALU_ADD, 0, 0));
        tbl.push_back(mk("blt_ill", 7'b1100011, 3'b100, 7'h00, 0, ALU_ADD, 0, 0));
        tbl.push_back(mk("slli_ill",7'b0010011, 3'b001, 7'h00, 0, ALU_ADD, 0, 0));

        reset_seq();
        for (int i = 0; i < tbl.size(); i++) begin
            run_instr(tbl[i], 0, 0);
            if (!tbl[i].legal) reset_seq();
        end

        // Store with three not-ready cycles; request and write held throughout.
        run_instr(tbl[1], 0, 3);
        // Ready on the last permitted wait cycle wins over the timeout.
        run_instr(tbl[2], 14, 0);
        run_instr(tbl[0], 14, 14);

        // Fetch stuck not-ready: 15 wait cycles, then trap with bus_error and no outputs.
        reset_seq();
        opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00;
        v = '0; v.mem_req = 1;
        repeat (15) begin
            mem_ready = 1'b0;
            cycle("fetch_stuck", v);
        end
        v = '0; v.bus = 1;
        repeat (3) begin
            mem_ready = 1'($urandom_range(0, 1));
            cycle("bus_trap", v);
        end
        reset_seq();

        // Variant with bne and jal disabled traps on them; beq stays legal.
        run_instr(tbl[10], 0, 0);
        check_bit("nobj_beq_legal", b_illegal_instr, 1'b0);
        run_instr(tbl[12], 0, 0);
        check_bit("nobj_bne_illegal", b_illegal_instr, 1'b1);
        check_bit("nobj_bne_memreq", b_mem_req, 1'b0);
        reset_seq();
        run_instr(tbl[14], 0, 0);
        check_bit("nobj_jal_illegal", b_illegal_instr, 1'b1);
        check_bit("main_jal_legal", illegal_instr, 1'b0);

        // Reset asserted in the middle of a load's memory read.
        reset_seq();
        opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'h00;
        mem_ready = 1'b1;
        v = '0; v.mem_req = 1; v.ir_write = 1; v.pc_write = 1; v.b = 2'd2; v.rs = 2'd2;
        cycle("lw_fetch", v);
        mem_ready = 1'b0;
        v = '0; v.a = 2'd1; v.b = 2'd1; v.imm = IMM_SRC_B;
        cycle("lw_decode", v);
        v = '0; v.a = 2'd2; v.b = 2'd1; v.imm = IMM_SRC_I;
        cycle("lw_memadr", v);
        #2;
        v = '0; v.mem_req = 1; v.adr_src = 1;
        check("lw_memread", v);
        rst = 1'b1;
        #1;
        check("rst_async_memread", '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("idle_after_rst", '0);

        // Random legal programs with random memory latency, ending in a random illegal opcode.
        for (int k = 0; k < 80; k++) begin
            int unsigned cls;
            cls = $urandom_range(0, 5);
            r = mk("rnd", 7'b0000011, 3'($urandom_range(0, 7)), 7'($urandom), 0, ALU_ADD, 0, 1);
            case (cls)
                0: r.name = "rnd_lw";
                1: begin r.name = "rnd_sw"; r.op = 7'b0100011; end
                2: begin
                    r.name = "rnd_r"; r.op = 7'b0110011;
                    r.f3 = alu_f3s[$urandom_range(0, 3)];
                    r.f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    r.alu = ref_alu(1'b1, r.f3, r.f7);
                end
                3: begin
                    r.name = "rnd_i"; r.op = 7'b0010011;
                    r.f3 = alu_f3s[$urandom_range(0, 3)];
                    r.alu = ref_alu(1'b0, r.f3, r.f7);
                end
                4: begin
                    r.name = "rnd_br"; r.op = 7'b1100011;
                    r.f3 = 3'($urandom_range(0, 1));
                    r.zero = 1'($urandom_range(0, 1));
                    r.taken = (r.f3 == 3'b000) ? r.zero : !r.zero;
                end
                default: begin r.name = "rnd_jal"; r.op = 7'b1101111; end
            endcase
            run_instr(r, -1, -1);
        end
        r = mk("rnd_illegal_op", 7'($urandom), 3'($urandom_range(0, 7)), 7'($urandom), 0, ALU_ADD, 0, 0);
        while (is_legal_op(r.op)) r.op = 7'($urandom);
        run_instr(r, -1, -1);
        reset_seq();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
